switch_reader: RTL and testbench
================================

SWITCH_READER -- requirements
Module: switch_reader

Interface
REQ-001 Parameter WIDTH, default 16, number of serial input bits captured per scan (2..32).
REQ-002 Parameter DIV, default 4, system clock cycles per serial-clock half-period (1..255).
REQ-003 Port i_CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 Port i_RESET  input  1  asynchronous, active-low reset.
REQ-005 Port i_Enable  input  1  request scans; sampled only in IDLE.
REQ-006 Port i_SerData  input  1  serial data from the external parallel-in/serial-out register.
REQ-007 Port o_SHCLK  output  1  serial shift clock to the external register.
REQ-008 Port o_SHLoad  output  1  parallel-load strobe to the external register, active low.
REQ-009 Port o_Data  output  WIDTH  last completed scan, MSB = first bit received.
REQ-010 Port o_Valid  output  1  one-cycle pulse, o_Data updated this cycle.
REQ-011 Port o_Busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The block SHALL implement FSM states IDLE, LOAD, SHIFT, DONE; all outputs SHALL be registered.
REQ-013 IDLE: o_SHLoad=1, o_SHCLK=0; i_Enable=1 at a rising edge -> LOAD at that edge (edge E0), else stay.
REQ-014 LOAD: o_SHLoad=0, o_SHCLK=0 for exactly 2*DIV cycles; then -> SHIFT with bit counter 0, o_SHLoad=1.
REQ-015 SHIFT, per bit: low phase DIV cycles (o_SHCLK=0), then high phase DIV cycles (o_SHCLK=1).
REQ-016 i_SerData SHALL be sampled on the last cycle of each low phase and shifted into an internal WIDTH-bit register from the LSB end, so the first bit lands in bit WIDTH-1 after WIDTH samples.
REQ-017 After the high phase of bit WIDTH-1 -> DONE; bit counter SHALL count 0..WIDTH-1 with no wrap inside a scan.
REQ-018 On the edge entering DONE, o_Data SHALL load the full shift register and o_Valid SHALL go high, i.e. 2*DIV*(WIDTH+1) cycles after E0 (136 for defaults).
REQ-019 DONE lasts exactly one cycle, o_SHCLK=0, o_SHLoad=1; -> IDLE; o_Valid returns to 0 on leaving DONE.
REQ-020 Back-to-back scans: with i_Enable held high, next LOAD SHALL start one cycle after DONE (IDLE occupied one cycle); scan period 2*DIV*(WIDTH+1)+2 cycles.
REQ-021 i_Enable deasserted during LOAD/SHIFT/DONE SHALL NOT abort the scan.
REQ-022 o_Data SHALL hold its value between o_Valid pulses; partial scans SHALL never reach o_Data.
REQ-023 Half-period counter SHALL be 8 bits wide and reload to DIV-1 at each phase boundary; DIV=1 gives 1-cycle phases.
REQ-024 o_Busy SHALL be high in LOAD, SHIFT and DONE, low in IDLE.

Reset
REQ-025 i_RESET=0 SHALL immediately force: state IDLE, o_SHCLK=0, o_SHLoad=1, o_Data=0, o_Valid=0, o_Busy=0, counters and shift register 0.
REQ-026 Reset asserted mid-scan SHALL abort with no o_Valid pulse and o_Data=0; after release the block SHALL wait in IDLE for i_Enable.
REQ-027 Reset release SHALL be synchronous to i_CLK internally (no state change on the release edge itself other than IDLE evaluation).

Verification
REQ-028 Defaults, external model holds 16'hA5C3, single i_Enable pulse -> o_SHLoad low 8 cycles, 16 o_SHCLK pulses of 4 high/4 low, o_Valid one cycle at E0+136, o_Data=16'hA5C3.
REQ-029 i_Enable held high, model value changes 16'h0001 -> 16'h8000 between scans -> consecutive o_Valid 138 cycles apart, o_Data 16'h0001 then 16'h8000.
REQ-030 DIV=1, WIDTH=8, pattern 8'h5A -> o_SHCLK toggles every cycle during SHIFT, o_Valid at E0+18, o_Data=8'h5A.
REQ-031 Reset pulsed low at bit 7 of a scan -> outputs at reset values within the same cycle, no o_Valid, o_Data=0, next scan returns correct value.
REQ-032 i_Enable dropped 10 cycles after E0 -> scan completes, single o_Valid, block remains in IDLE with o_Busy=0.

Source files
------------

// File: rtl/switch_reader.sv
// Scans an external parallel-in/serial-out register: parallel-load strobe, then
// WIDTH serial clock pulses, then publishes the captured word with a one-cycle valid.
module switch_reader #(
  parameter int WIDTH = 16,
  parameter int DIV   = 4
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic             i_Enable,
  input  logic             i_SerData,
  output logic             o_SHCLK,
  output logic             o_SHLoad,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_Valid,
  output logic             o_Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] DIV_M1   = 8'(DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [5:0]       bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             shclk_q, shclk_d;
  logic             shload_q, shload_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  // Next-state and registered-output logic; LOAD and each bit are two DIV-cycle phases.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    shclk_d  = shclk_q;
    shload_d = shload_q;
    data_d   = data_q;
    valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        shclk_d  = 1'b0;
        shload_d = 1'b1;
        if (i_Enable) begin
          state_d  = LOAD;
          cnt_d    = DIV_M1;
          phase_d  = 1'b0;
          shload_d = 1'b0;
        end else begin
          state_d  = IDLE;
        end
      end

      LOAD: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (!phase_q) begin
          phase_d = 1'b1;
          cnt_d   = DIV_M1;
        end else begin
          state_d  = SHIFT;
          phase_d  = 1'b0;
          cnt_d    = DIV_M1;
          bit_d    = 6'd0;
          shload_d = 1'b1;
        end
      end

      SHIFT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (!phase_q) begin
          // Sample just before the rising shift clock moves the next bit out.
          phase_d = 1'b1;
          cnt_d   = DIV_M1;
          shclk_d = 1'b1;
          shreg_d = {shreg_q[WIDTH-2:0], i_SerData};
        end else begin
          phase_d = 1'b0;
          cnt_d   = DIV_M1;
          shclk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            state_d = DONE;
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end
      end

      DONE: begin
        state_d  = IDLE;
        shclk_d  = 1'b0;
        shload_d = 1'b1;
      end

      default: begin
        state_d  = IDLE;
        shclk_d  = 1'b0;
        shload_d = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset clears everything including the published word.
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      phase_q  <= 1'b0;
      bit_q    <= 6'd0;
      shreg_q  <= {WIDTH{1'b0}};
      shclk_q  <= 1'b0;
      shload_q <= 1'b1;
      data_q   <= {WIDTH{1'b0}};
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      shclk_q  <= shclk_d;
      shload_q <= shload_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign o_SHCLK  = shclk_q;
  assign o_SHLoad = shload_q;
  assign o_Data   = data_q;
  assign o_Valid  = valid_q;
  assign o_Busy   = busy_q;

endmodule

// File: tb/tb_switch_reader.sv
// Scoreboard bench for switch_reader: two instances (defaults, and DIV=1/WIDTH=8)
// each driven by a behavioural PISO register model.
module tb_switch_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  // Instance A: default parameters
  logic        rst_a, en_a, ser_a;
  logic        shclk_a, shload_a, valid_a, busy_a;
  logic [15:0] data_a;
  logic [15:0] mval_a = 16'h0000, mreg_a = 16'h0000;
  logic        pclk_a = 1'b0;

  switch_reader dut_a (
    .i_CLK(clk), .i_RESET(rst_a), .i_Enable(en_a), .i_SerData(ser_a),
    .o_SHCLK(shclk_a), .o_SHLoad(shload_a), .o_Data(data_a),
    .o_Valid(valid_a), .o_Busy(busy_a)
  );

  // Instance B: fastest serial clock, 8-bit scan
  logic        rst_b, en_b, ser_b;
  logic        shclk_b, shload_b, valid_b, busy_b;
  logic [7:0]  data_b;
  logic [7:0]  mval_b = 8'h00, mreg_b = 8'h00;
  logic        pclk_b = 1'b0;

  switch_reader #(.WIDTH(8), .DIV(1)) dut_b (
    .i_CLK(clk), .i_RESET(rst_b), .i_Enable(en_b), .i_SerData(ser_b),
    .o_SHCLK(shclk_b), .o_SHLoad(shload_b), .o_Data(data_b),
    .o_Valid(valid_b), .o_Busy(busy_b)
  );

  // External PISO models: parallel load while strobe low, shift on shift-clock rise.
  always @(posedge clk) begin
    pclk_a <= shclk_a;
    if (shload_a === 1'b0) mreg_a <= mval_a;
    else if (shclk_a === 1'b1 && pclk_a === 1'b0) mreg_a <= {mreg_a[14:0], 1'b0};
    pclk_b <= shclk_b;
    if (shload_b === 1'b0) mreg_b <= mval_b;
    else if (shclk_b === 1'b1 && pclk_b === 1'b0) mreg_b <= {mreg_b[6:0], 1'b0};
  end
  assign ser_a = mreg_a[15];
  assign ser_b = mreg_b[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Waveform statistics sampled mid-cycle
  int lo_a = 0, hi_a = 0, pu_a = 0, hi_b = 0, pu_b = 0;
  logic pv_a = 1'b0, pv_b = 1'b0;
  always @(negedge clk) begin
    if (shload_a === 1'b0) lo_a <= lo_a + 1;
    if (shclk_a === 1'b1) hi_a <= hi_a + 1;
    if (shclk_a === 1'b1 && pv_a === 1'b0) pu_a <= pu_a + 1;
    pv_a <= shclk_a;
    if (shclk_b === 1'b1) hi_b <= hi_b + 1;
    if (shclk_b === 1'b1 && pv_b === 1'b0) pu_b <= pu_b + 1;
    pv_b <= shclk_b;
  end

  // Monitor A
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (valid_a === 1'b1) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_valid", {16'h0, data_a}, 32'hFFFF_FFFF);
      end else begin
        e = q_a.pop_front();
        check("a_data", {16'h0, data_a}, {16'h0, e.d});
        check("a_valid_time", cyc, e.c);
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (valid_b === 1'b1) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_valid", {24'h0, data_b}, 32'hFFFF_FFFF);
      end else begin
        e = q_b.pop_front();
        check("b_data", {24'h0, data_b}, {16'h0, e.d});
        check("b_valid_time", cyc, e.c);
      end
    end
  end

  int e0;
  int s_lo, s_hi, s_pu;

  // Issue one enable, return the index of the edge that took it (E0).
  task automatic start_a(input logic [15:0] val);
    @(negedge clk);
    mval_a = val;
    en_a = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
  endtask

  initial begin
    rst_a = 1'b0; en_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_shclk", {31'h0, shclk_a}, 32'd0);
    check("rst_shload", {31'h0, shload_a}, 32'd1);
    check("rst_data", {16'h0, data_a}, 32'd0);
    check("rst_valid", {31'h0, valid_a}, 32'd0);
    check("rst_busy", {31'h0, busy_a}, 32'd0);
    check("rst_b_shload", {31'h0, shload_b}, 32'd1);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);

    // Single scan of A5C3 with waveform statistics
    s_lo = lo_a; s_hi = hi_a; s_pu = pu_a;
    start_a(16'hA5C3);
    q_a.push_back('{d: 16'hA5C3, c: e0 + 136});
    @(negedge clk); en_a = 1'b0;
    repeat (4) @(negedge clk);
    check("t1_busy_in_load", {31'h0, busy_a}, 32'd1);
    check("t1_shload_low", {31'h0, shload_a}, 32'd0);
    repeat (140) @(negedge clk);
    check("t1_missing_valid", q_a.size(), 32'd0);
    check("t1_shload_low_cycles", lo_a - s_lo, 32'd8);
    check("t1_shclk_pulses", pu_a - s_pu, 32'd16);
    check("t1_shclk_high_cycles", hi_a - s_hi, 32'd64);
    check("t1_idle_busy", {31'h0, busy_a}, 32'd0);
    check("t1_data_hold", {16'h0, data_a}, 32'h0000_A5C3);

    // Back-to-back scans with enable held, model value changes between them
    start_a(16'h0001);
    q_a.push_back('{d: 16'h0001, c: e0 + 136});
    q_a.push_back('{d: 16'h8000, c: e0 + 274});
    repeat (138) @(negedge clk);
    mval_a = 16'h8000;
    repeat (5) @(negedge clk);
    en_a = 1'b0;
    repeat (140) @(negedge clk);
    check("t2_missing_valid", q_a.size(), 32'd0);
    check("t2_busy", {31'h0, busy_a}, 32'd0);
    check("t2_data", {16'h0, data_a}, 32'h0000_8000);

    // Enable dropped 10 cycles into the scan must not abort it
    start_a(16'h3C96);
    q_a.push_back('{d: 16'h3C96, c: e0 + 136});
    repeat (10) @(negedge clk);
    en_a = 1'b0;
    repeat (140) @(negedge clk);
    check("t3_missing_valid", q_a.size(), 32'd0);
    repeat (5) @(negedge clk);
    check("t3_stays_idle", {31'h0, busy_a}, 32'd0);

    // Reset in the middle of bit 7
    start_a(16'h1234);
    @(negedge clk); en_a = 1'b0;
    repeat (67) @(negedge clk);
    check("t4_busy_before_rst", {31'h0, busy_a}, 32'd1);
    rst_a = 1'b0;
    #1;
    check("t4_rst_shclk", {31'h0, shclk_a}, 32'd0);
    check("t4_rst_shload", {31'h0, shload_a}, 32'd1);
    check("t4_rst_data", {16'h0, data_a}, 32'd0);
    check("t4_rst_valid", {31'h0, valid_a}, 32'd0);
    check("t4_rst_busy", {31'h0, busy_a}, 32'd0);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    repeat (150) @(negedge clk);
    check("t4_after_rst_busy", {31'h0, busy_a}, 32'd0);
    check("t4_after_rst_data", {16'h0, data_a}, 32'd0);
    start_a(16'hF00F);
    q_a.push_back('{d: 16'hF00F, c: e0 + 136});
    @(negedge clk); en_a = 1'b0;
    repeat (140) @(negedge clk);
    check("t4_missing_valid", q_a.size(), 32'd0);

    // DIV=1, WIDTH=8
    s_hi = hi_b; s_pu = pu_b;
    @(negedge clk);
    mval_b = 8'h5A;
    en_b = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    q_b.push_back('{d: 16'h005A, c: e0 + 18});
    @(negedge clk); en_b = 1'b0;
    repeat (25) @(negedge clk);
    check("t5_missing_valid", q_b.size(), 32'd0);
    check("t5_shclk_pulses", pu_b - s_pu, 32'd8);
    check("t5_shclk_high_cycles", hi_b - s_hi, 32'd8);
    check("t5_busy", {31'h0, busy_b}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
